sa_driver: RTL and testbench

Host-side sequencer for the 4x4 output-stationary systolic multiply array (16 PEs, SIZE-bit operands, 2*SIZE-bit accumulators).
- Holds 4x4 operand matrices A and B, loaded through a simple write port.
- On start, clears the array and streams A rows and B columns into the array edges with the diagonal skew the array requires.
- Then captures the 16 accumulator outputs c1..c16 into a readable result bank.
- Computes C = A x B, modulo 2^(2*SIZE).

---
 rtl/sa_pkg.sv | 26 ++
 rtl/sa_driver_if.sv | 51 +++++
 rtl/sa_skew_mux.sv | 31 +++
 rtl/sa_driver.sv | 200 ++++++++++++++++++++
 tb/tb_sa_driver.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array host sequencer (sa_driver).
// Holds array geometry, the sequencer state type and the result-width helper.
package sa_pkg;

  // Array is SA_DIM x SA_DIM processing elements.
  localparam int SA_DIM = 4;
  localparam int SA_CELLS = SA_DIM * SA_DIM;

  // Diagonal skew needs 3*SA_DIM-2 feed cycles before the last PE sees its
  // last operand pair.
  localparam int SA_FEED_CYCLES = 3 * SA_DIM - 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } sa_drv_state_t;

  // Accumulators (and therefore results) are twice the operand width.
  function automatic int sa_res_w(input int size);
    return 2 * size;
  endfunction

endpackage

// File: rtl/sa_driver_if.sv
// Host-side bus of sa_driver: operand write port, start/busy/done and the
// result read port. Optional accumulate input under SA_DRV_ACCUM_EN.
//
// Handshake: the host may pulse wr_en or start only while busy=0. start is
// accepted in IDLE; busy rises the next cycle and stays high until the done
// cycle. done is a one-cycle pulse; results on rd_data (combinational from
// rd_addr) are valid from that cycle until the next capture or reset.
// Writes and starts presented while busy, or in the done cycle (start), are
// dropped silently.
interface sa_driver_if
  import sa_pkg::*;
#(
  parameter int SIZE = 10
);
  localparam int RW = sa_res_w(SIZE);

  logic            wr_en;
  logic            wr_sel;
  logic [3:0]      wr_addr;
  logic [SIZE-1:0] wr_data;
  logic            start;
`ifdef SA_DRV_ACCUM_EN
  logic            accumulate;
`endif
  logic            busy;
  logic            done;
  logic [3:0]      rd_addr;
  logic [RW-1:0]   rd_data;
  sa_drv_state_t   dbg_state;

`ifdef SA_DRV_ACCUM_EN
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, accumulate, rd_addr,
    input  busy, done, rd_data, dbg_state
  );
  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, accumulate, rd_addr,
    output busy, done, rd_data, dbg_state
  );
`else
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    input  busy, done, rd_data, dbg_state
  );
  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    output busy, done, rd_data, dbg_state
  );
`endif

endinterface

// File: rtl/sa_skew_mux.sv
// Combinational diagonal-skew selector: for feed step t, row i of the array
// gets A[i][t-i] and column j gets B[t-j][j]; out-of-window lanes are zero.
module sa_skew_mux
  import sa_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic [3:0]      i_t,
  input  logic [SIZE-1:0] i_a_mat [SA_CELLS],
  input  logic [SIZE-1:0] i_b_mat [SA_CELLS],
  output logic [SIZE-1:0] o_a     [SA_DIM],
  output logic [SIZE-1:0] o_b     [SA_DIM]
);

  // Lane i picks element k where t == i + k; no match means zero.
  always_comb begin
    for (int i = 0; i < SA_DIM; i++) begin
      o_a[i] = '0;
      o_b[i] = '0;
    end
    for (int i = 0; i < SA_DIM; i++) begin
      for (int k = 0; k < SA_DIM; k++) begin
        if (i_t == 4'(i + k)) begin
          o_a[i] = i_a_mat[4'(i * SA_DIM + k)];
          o_b[i] = i_b_mat[4'(k * SA_DIM + i)];
        end
      end
    end
  end

endmodule

// File: rtl/sa_driver.sv
// Host-side sequencer for the 4x4 output-stationary systolic multiply array.
// Holds operand matrices A and B, clears the array, streams skewed rows of A
// and columns of B into the array edges, then captures the 16 accumulators
// into a readable result bank. Results wrap modulo 2^(2*SIZE).
// Optional feature macro: SA_DRV_ACCUM_EN adds an accumulate input that
// skips the array clear so the new product adds onto the previous sums.
module sa_driver
  import sa_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic                clk,
  input  logic                reset,
  sa_driver_if.slave          host,
  output logic                sa_reset,
  output logic [SIZE-1:0]     sa_a1, sa_a2, sa_a3, sa_a4,
  output logic [SIZE-1:0]     sa_b1, sa_b2, sa_b3, sa_b4,
  input  logic [2*SIZE-1:0]   sa_c1,  sa_c2,  sa_c3,  sa_c4,
  input  logic [2*SIZE-1:0]   sa_c5,  sa_c6,  sa_c7,  sa_c8,
  input  logic [2*SIZE-1:0]   sa_c9,  sa_c10, sa_c11, sa_c12,
  input  logic [2*SIZE-1:0]   sa_c13, sa_c14, sa_c15, sa_c16
);

  localparam int RW = sa_res_w(SIZE);

  sa_drv_state_t   r_state;
  sa_drv_state_t   w_state_next;
  logic [3:0]      r_t;
  logic [3:0]      w_load_t;
  logic            w_load_en;
  logic            w_capture;
  logic            w_idle;
  logic            w_wr_fire;
  logic            w_accum;

  logic [SIZE-1:0] r_a_mat  [SA_CELLS];
  logic [SIZE-1:0] r_b_mat  [SA_CELLS];
  logic [SIZE-1:0] w_a_next [SA_CELLS];
  logic [SIZE-1:0] w_b_next [SA_CELLS];
  logic [RW-1:0]   r_res    [SA_CELLS];
  logic [RW-1:0]   w_c      [SA_CELLS];

  logic [SIZE-1:0] w_skew_a [SA_DIM];
  logic [SIZE-1:0] w_skew_b [SA_DIM];
  logic [SIZE-1:0] r_sa_a   [SA_DIM];
  logic [SIZE-1:0] r_sa_b   [SA_DIM];

  assign w_idle    = (r_state == IDLE);
  assign w_wr_fire = w_idle && host.wr_en;

`ifdef SA_DRV_ACCUM_EN
  assign w_accum = host.accumulate;
`else
  assign w_accum = 1'b0;
`endif

  // Next-state and feed-step control; w_load_t is the feed step whose edge
  // values must be registered now so they appear in the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_load_en    = 1'b0;
    w_load_t     = '0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (host.start) begin
          if (w_accum) begin
            w_state_next = FEED;
            w_load_en    = 1'b1;
          end else begin
            w_state_next = CLR;
          end
        end
      end
      CLR: begin
        w_state_next = FEED;
        w_load_en    = 1'b1;
      end
      FEED: begin
        if (r_t == 4'(SA_FEED_CYCLES - 1)) begin
          w_state_next = CAPT;
        end else begin
          w_load_en = 1'b1;
          w_load_t  = r_t + 4'd1;
        end
      end
      CAPT: begin
        w_capture    = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register and feed-step counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_next;
      r_t     <= w_load_en ? w_load_t : 4'd0;
    end
  end

  // Operand matrices as they will be after this cycle's write, so a write
  // issued together with start is already visible to the skew selector.
  always_comb begin
    w_a_next = r_a_mat;
    w_b_next = r_b_mat;
    if (w_wr_fire) begin
      if (host.wr_sel) begin
        w_b_next[host.wr_addr] = host.wr_data;
      end else begin
        w_a_next[host.wr_addr] = host.wr_data;
      end
    end
  end

  // Operand storage; persists across runs, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SA_CELLS; i++) begin
        r_a_mat[i] <= '0;
        r_b_mat[i] <= '0;
      end
    end else begin
      r_a_mat <= w_a_next;
      r_b_mat <= w_b_next;
    end
  end

  sa_skew_mux #(
    .SIZE (SIZE)
  ) u_skew (
    .i_t     (w_load_t),
    .i_a_mat (w_a_next),
    .i_b_mat (w_b_next),
    .o_a     (w_skew_a),
    .o_b     (w_skew_b)
  );

  // Edge registers: hold the skewed values during FEED, zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SA_DIM; i++) begin
        r_sa_a[i] <= '0;
        r_sa_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SA_DIM; i++) begin
        r_sa_a[i] <= w_load_en ? w_skew_a[i] : '0;
        r_sa_b[i] <= w_load_en ? w_skew_b[i] : '0;
      end
    end
  end

  assign w_c[0]  = sa_c1;   assign w_c[1]  = sa_c2;
  assign w_c[2]  = sa_c3;   assign w_c[3]  = sa_c4;
  assign w_c[4]  = sa_c5;   assign w_c[5]  = sa_c6;
  assign w_c[6]  = sa_c7;   assign w_c[7]  = sa_c8;
  assign w_c[8]  = sa_c9;   assign w_c[9]  = sa_c10;
  assign w_c[10] = sa_c11;  assign w_c[11] = sa_c12;
  assign w_c[12] = sa_c13;  assign w_c[13] = sa_c14;
  assign w_c[14] = sa_c15;  assign w_c[15] = sa_c16;

  // Result bank: latched once per run in CAPT, held until next CAPT/reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SA_CELLS; i++) begin
        r_res[i] <= '0;
      end
    end else if (w_capture) begin
      r_res <= w_c;
    end
  end

  // The array clears in the same cycle as this block, hence combinational.
  assign sa_reset = reset | (r_state == CLR);

  assign sa_a1 = r_sa_a[0];
  assign sa_a2 = r_sa_a[1];
  assign sa_a3 = r_sa_a[2];
  assign sa_a4 = r_sa_a[3];
  assign sa_b1 = r_sa_b[0];
  assign sa_b2 = r_sa_b[1];
  assign sa_b3 = r_sa_b[2];
  assign sa_b4 = r_sa_b[3];

  assign host.busy      = (r_state == CLR) || (r_state == FEED) || (r_state == CAPT);
  assign host.done      = (r_state == DONE);
  assign host.rd_data   = r_res[host.rd_addr];
  assign host.dbg_state = r_state;

endmodule

// File: tb/tb_sa_driver.sv
// Bench for sa_driver paired with a behavioural 4x4 output-stationary array.
// A matrix-level model predicts results; a per-cycle compare process checks
// busy/done/sa_reset and the skewed edge inputs; literal spot checks pin it.
module tb_sa_driver;
  import sa_pkg::*;

  localparam int SIZE = 10;
  localparam int RW   = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT + array model ----------------
  sa_driver_if #(.SIZE(SIZE)) u_if ();

  logic            sa_reset;
  logic [SIZE-1:0] sa_a1, sa_a2, sa_a3, sa_a4;
  logic [SIZE-1:0] sa_b1, sa_b2, sa_b3, sa_b4;
  logic [RW-1:0]   m_c  [4][4];
  logic [SIZE-1:0] m_ar [4][4];
  logic [SIZE-1:0] m_br [4][4];
  logic [SIZE-1:0] pa_in [4][4];
  logic [SIZE-1:0] pb_in [4][4];
  logic [SIZE-1:0] edge_a [4];
  logic [SIZE-1:0] edge_b [4];

  sa_driver #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .host     (u_if),
    .sa_reset (sa_reset),
    .sa_a1 (sa_a1), .sa_a2 (sa_a2), .sa_a3 (sa_a3), .sa_a4 (sa_a4),
    .sa_b1 (sa_b1), .sa_b2 (sa_b2), .sa_b3 (sa_b3), .sa_b4 (sa_b4),
    .sa_c1  (m_c[0][0]), .sa_c2  (m_c[0][1]), .sa_c3  (m_c[0][2]), .sa_c4  (m_c[0][3]),
    .sa_c5  (m_c[1][0]), .sa_c6  (m_c[1][1]), .sa_c7  (m_c[1][2]), .sa_c8  (m_c[1][3]),
    .sa_c9  (m_c[2][0]), .sa_c10 (m_c[2][1]), .sa_c11 (m_c[2][2]), .sa_c12 (m_c[2][3]),
    .sa_c13 (m_c[3][0]), .sa_c14 (m_c[3][1]), .sa_c15 (m_c[3][2]), .sa_c16 (m_c[3][3])
  );

  assign edge_a[0] = sa_a1; assign edge_a[1] = sa_a2;
  assign edge_a[2] = sa_a3; assign edge_a[3] = sa_a4;
  assign edge_b[0] = sa_b1; assign edge_b[1] = sa_b2;
  assign edge_b[2] = sa_b3; assign edge_b[3] = sa_b4;

  // PE operand inputs: left/top edge or neighbour's registered pass-through.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pa_in[i][0] = edge_a[i];
      pb_in[0][i] = edge_b[i];
      for (int j = 1; j < 4; j++) begin
        pa_in[i][j] = m_ar[i][j-1];
        pb_in[j][i] = m_br[j-1][i];
      end
    end
  end

  // Array: each PE accumulates a*b and forwards a right, b down.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (sa_reset) begin
          m_c[i][j]  <= '0;
          m_ar[i][j] <= '0;
          m_br[i][j] <= '0;
        end else begin
          m_c[i][j]  <= m_c[i][j] + (RW'(pa_in[i][j]) * RW'(pb_in[i][j]));
          m_ar[i][j] <= pa_in[i][j];
          m_br[i][j] <= pb_in[i][j];
        end
      end
    end
  end

  // ---------------- model state / scoreboard ----------------
  logic [SIZE-1:0] ma [4][4];
  logic [SIZE-1:0] mb [4][4];
  logic [RW-1:0]   prev_c [4][4];
  logic [RW-1:0]   exp_c  [4][4];
  logic [RW-1:0]   exp_q [$];
  int  start_cyc = -1;
  bit  run_accum = 1'b0;
  bit  cmp_en    = 1'b0;
  int  checks    = 0;
  int  failures  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int              c_rel, c_fs, c_capt, c_t;
  logic            e_busy, e_done, e_sr;
  logic [SIZE-1:0] e_a, e_b;

  // Timeline model: positions relative to the start cycle decide phase.
  always @(negedge clk) begin
    if (cmp_en) begin
      e_busy = 1'b0;
      e_done = 1'b0;
      e_sr   = reset;
      c_t    = -1;
      if (start_cyc >= 0) begin
        c_rel  = cyc - start_cyc;
        c_fs   = run_accum ? 1 : 2;
        c_capt = c_fs + SA_FEED_CYCLES;
        if (c_rel >= 1 && c_rel <= c_capt) e_busy = 1'b1;
        if (c_rel == c_capt + 1) e_done = 1'b1;
        if (!run_accum && c_rel == 1) e_sr = 1'b1;
        if (c_rel >= c_fs && c_rel < c_fs + SA_FEED_CYCLES) c_t = c_rel - c_fs;
      end
      chk("busy", 32'(u_if.busy), 32'(e_busy));
      chk("done", 32'(u_if.done), 32'(e_done));
      chk("sa_reset", 32'(sa_reset), 32'(e_sr));
      for (int i = 0; i < 4; i++) begin
        e_a = '0;
        e_b = '0;
        if (c_t >= i && c_t - i <= 3) begin
          e_a = ma[i][c_t - i];
          e_b = mb[c_t - i][i];
        end
        chk($sformatf("sa_a%0d", i + 1), 32'(edge_a[i]), 32'(e_a));
        chk($sformatf("sa_b%0d", i + 1), 32'(edge_b[i]), 32'(e_b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input bit sel, input int row, input int col, input int val);
    u_if.wr_en   = 1'b1;
    u_if.wr_sel  = sel;
    u_if.wr_addr = 4'(row * 4 + col);
    u_if.wr_data = SIZE'(val);
    if (sel) mb[row][col] = SIZE'(val);
    else     ma[row][col] = SIZE'(val);
    tick();
    u_if.wr_en = 1'b0;
  endtask

  task automatic read_check();
    logic [RW-1:0] e;
    for (int a = 0; a < 16; a++) begin
      u_if.rd_addr = 4'(a);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("rd%0d", a), 32'(u_if.rd_data), 32'(e));
    end
  endtask

  task automatic check_rd_lit(input int addr, input int val);
    u_if.rd_addr = 4'(addr);
    #1;
    chk($sformatf("rd_lit%0d", addr), 32'(u_if.rd_data), 32'(val));
  endtask

  task automatic run_mult(input bit accum, input bit poke, input bit skew_lit,
                          input bit co_wr, input bit co_sel, input int co_row,
                          input int co_col, input int co_val);
    int lat;
    lat = 0;
    if (co_wr) begin
      u_if.wr_en   = 1'b1;
      u_if.wr_sel  = co_sel;
      u_if.wr_addr = 4'(co_row * 4 + co_col);
      u_if.wr_data = SIZE'(co_val);
      if (co_sel) mb[co_row][co_col] = SIZE'(co_val);
      else        ma[co_row][co_col] = SIZE'(co_val);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_c[i][j] = accum ? prev_c[i][j] : '0;
        for (int k = 0; k < 4; k++) begin
          exp_c[i][j] = exp_c[i][j] + (RW'(ma[i][k]) * RW'(mb[k][j]));
        end
      end
    end
    u_if.start = 1'b1;
`ifdef SA_DRV_ACCUM_EN
    u_if.accumulate = accum;
`endif
    run_accum = accum;
    start_cyc = cyc;
    tick();
    u_if.start = 1'b0;
    u_if.wr_en = 1'b0;
`ifdef SA_DRV_ACCUM_EN
    u_if.accumulate = 1'b0;
`endif
    for (int n = 1; n <= 20; n++) begin
      if (poke && (n == 1 || n == 5 || n == 12)) begin
        u_if.wr_en   = 1'b1;
        u_if.wr_sel  = 1'b1;
        u_if.wr_addr = 4'd0;
        u_if.wr_data = 10'd777;
        u_if.start   = 1'b1;
      end else begin
        u_if.wr_en = 1'b0;
        u_if.start = 1'b0;
      end
      if (skew_lit && n == (accum ? 1 : 2) + 3) begin
        chk("skew_a1", 32'(sa_a1), 32'd4);
        chk("skew_a4", 32'(sa_a4), 32'd13);
        chk("skew_b2", 32'(sa_b2), 32'd7);
      end
      if (u_if.done) begin
        lat = n;
        break;
      end
      tick();
    end
    u_if.wr_en = 1'b0;
    chk("done_latency", 32'(lat), accum ? 32'd12 : 32'd13);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        prev_c[i][j] = exp_c[i][j];
        exp_q.push_back(exp_c[i][j]);
      end
    read_check();
  endtask

  task automatic reset_mid_feed();
    int ndone;
    ndone = 0;
    u_if.start = 1'b1;
    run_accum  = 1'b0;
    start_cyc  = cyc;
    tick();
    u_if.start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("rst_sa_reset", 32'(sa_reset), 32'd1);
    tick();
    reset = 1'b0;
    start_cyc = -1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
        prev_c[i][j] = '0;
      end
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_state", 32'(u_if.dbg_state), 32'(IDLE));
    for (int n = 0; n < 20; n++) begin
      if (u_if.done) ndone++;
      tick();
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    for (int a = 0; a < 16; a++) exp_q.push_back('0);
    read_check();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset        = 1'b1;
    u_if.wr_en   = 1'b0;
    u_if.wr_sel  = 1'b0;
    u_if.wr_addr = '0;
    u_if.wr_data = '0;
    u_if.start   = 1'b0;
    u_if.rd_addr = '0;
`ifdef SA_DRV_ACCUM_EN
    u_if.accumulate = 1'b0;
`endif
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
        prev_c[i][j] = '0;
      end
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("reset_busy", 32'(u_if.busy), 32'd0);
    chk("reset_done", 32'(u_if.done), 32'd0);
    chk("reset_state", 32'(u_if.dbg_state), 32'(IDLE));
    for (int a = 0; a < 16; a++) exp_q.push_back('0);
    read_check();
    tick();
    reset = 1'b0;
    tick();

    // Identity A, B = 1..16; last B element written in the start cycle.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b0, r, c, (r == c) ? 1 : 0);
        if (r * 4 + c < 15) write_elem(1'b1, r, c, r * 4 + c + 1);
      end
    run_mult(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 3, 16);
    for (int a = 0; a < 16; a++) check_rd_lit(a, a + 1);

`ifdef SA_DRV_ACCUM_EN
    run_mult(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    check_rd_lit(0, 2);
    check_rd_lit(15, 32);
`endif

    // General operands, with ignored writes/starts while busy.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b0, r, c, r * 4 + c + 1);
        write_elem(1'b1, r, c, 16 - (r * 4 + c));
      end
    run_mult(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    check_rd_lit(0, 80);
    check_rd_lit(15, 386);

    // Back-to-back with B = I: results must equal A (array was cleared).
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_elem(1'b1, r, c, (r == c) ? 1 : 0);
    run_mult(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    check_rd_lit(5, 6);
    check_rd_lit(15, 16);

    // Wrap: all operands at maximum.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b0, r, c, 1023);
        write_elem(1'b1, r, c, 1023);
      end
    run_mult(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int a = 0; a < 16; a++) check_rd_lit(a, 1040388);

    // Reset during FEED step t=4.
    reset_mid_feed();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
